serial_frame_tx: RTL
====================

// Module: serial_frame_tx
// PURPOSE
//  Parallel-to-serial framer feeding the serial pattern detectors. Accepts WIDTH-bit words over
//  a valid/ready handshake, shifts them out one bit per clk on ser_out with a ser_valid qualifier,
//  then inserts an optional idle gap. Sits directly upstream of the detector's clk/rst/in port.
// PARAMETERS
//  WIDTH       8  bits per word, legal range 2..32
//  MSB_FIRST   1  1: data_in[WIDTH-1] is sent first; 0: data_in[0] is sent first
//  GAP_CYCLES  0  idle cycles inserted after each frame, legal range 0..255
//  IDLE_LEVEL  0  value driven on ser_out whenever ser_valid=0
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      reset: asynchronous assert, active-low (0 = reset)
//  data_in     in   WIDTH  word to serialise; sampled only on the accept cycle
//  data_valid  in   1      upstream has a word
//  data_ready  out  1      block can accept a word this cycle
//  ser_out     out  1      serial bit to the detector
//  ser_valid   out  1      ser_out carries a frame bit this cycle
//  busy        out  1      high in any state other than IDLE
//  frame_done  out  1      one-cycle pulse on the last bit of a frame (parity bit if enabled)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, shift reg=0, bit_cnt=0, gap_cnt=0; data_ready=0 while rst=0,
//   ser_out=IDLE_LEVEL, ser_valid=0, busy=0, frame_done=0. The first edge with rst=1 enters IDLE.
//  Accept: accept = data_valid & data_ready. data_ready = 1 in IDLE. In SHIFT it is 1 only on the
//   last data bit when GAP_CYCLES=0 and parity is disabled; this gives back-to-back frames with
//   no bubble. data_in is captured on the accept edge.
//  FSM: IDLE -accept-> SHIFT. SHIFT holds for WIDTH cycles, with bit_cnt counting 0..WIDTH-1.
//   After the last bit: PARITY if SER_PARITY_EN is defined; else GAP if GAP_CYCLES>0; else SHIFT
//   if an accept occurs on that cycle; else IDLE.
//   PARITY lasts 1 cycle, then goes to GAP or IDLE by the same rule.
//   GAP lasts exactly GAP_CYCLES cycles with ser_valid=0, then goes to IDLE.
//  Latency: the first bit of a frame appears on ser_out the cycle after accept (registered output).
//  Outputs in SHIFT/PARITY: ser_valid=1 and ser_out=current bit; all outputs are registered.
//  data_valid deasserted mid-frame: no effect. data_valid held in GAP: wait; the word is
//   accepted in IDLE on the following cycle.
//  Reset mid-frame: the frame is abandoned immediately and ser_out returns to IDLE_LEVEL within the
//   same cycle (async). No partial frame is resumed after reset.
//  bit_cnt width = $clog2(WIDTH); gap_cnt width = 8; neither counter ever wraps (terminal compare).
// CONFIGURATION
//  SER_PARITY_EN defined: after the WIDTH data bits, one extra bit = even parity (^word), sent with
//   ser_valid=1; frame_done pulses on the parity bit; frame length = WIDTH+1.
//  SER_PARITY_EN undefined: no PARITY state, frame length = WIDTH, frame_done on the last data bit.
// STRUCTURE
//  Package ser_pkg: typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY, ST_GAP} ser_state_t;
//   localparam GAP_CNT_W = 8.
//  Single module: shift register, bit counter, gap counter and FSM inline. No sub-module.
// TESTING
//  1. Reset: rst=0 for 3 cycles with data_valid=1 -> ser_valid=0, data_ready=0, ser_out=IDLE_LEVEL.
//  2. WIDTH=8, MSB_FIRST=1, accept 8'hE6 -> bits 1,1,1,0,0,1,1,0 on 8 consecutive cycles starting
//     1 cycle after accept; frame_done on bit 8.
//  3. Back-to-back: GAP_CYCLES=0, data_valid held with words 8'hE6 then 8'hDB -> 16 contiguous
//     ser_valid cycles; data_ready high on cycle 8 only.
//  4. GAP_CYCLES=3 -> exactly 3 ser_valid=0 cycles between frames; data_ready=0 throughout the gap.
//  5. Assert rst at bit 4 of a frame -> ser_valid drops asynchronously; the next accepted word is
//     sent in full from bit 0.
//  6. SER_PARITY_EN defined, word 8'h07 -> 9th bit = 1 with ser_valid=1; frame_done on the 9th bit.
//  Chained check: drive the detector's serial input from ser_out (gated by ser_valid) and confirm
//   the detector's match output fires on the expected frame.

Source files
------------

// File: rtl/ser_pkg.sv
// ser_pkg: shared state encoding and counter widths for the serial framer
package ser_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY, ST_GAP} ser_state_t;
  localparam int GAP_CNT_W = 8;
endpackage

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: valid/ready word to serial bit stream framer; SER_PARITY_EN appends an even-parity bit
module serial_frame_tx
  import ser_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             frame_done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  ser_state_t           state, nxt, tail;
  logic [WIDTH-1:0]     sr;
  logic [CW-1:0]        bit_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 live, last, accept, par_bit;
  assign last   = bit_cnt == LAST_BIT;
  assign accept = data_valid & data_ready;
  // ready in IDLE, or on the last data bit when the next frame may follow with no bubble
  assign data_ready = live & ((state == ST_IDLE) |
                      ((state == ST_SHIFT) & last & !PAR_EN & (GAP_CYCLES == 0)));
`ifdef SER_PARITY_EN
  // even parity of the word, captured alongside it
  always_ff @(posedge clk or negedge rst)
    if (!rst) par_bit <= 1'b0;
    else if (accept) par_bit <= ^data_in;
`else
  assign par_bit = IDLE_LEVEL;
`endif
  // where a frame goes once its body (data plus optional parity) is done
  always_comb begin
    tail = (GAP_CYCLES > 0) ? ST_GAP : (accept ? ST_SHIFT : ST_IDLE);
    nxt  = state == ST_IDLE   ? (accept ? ST_SHIFT : ST_IDLE) :
           state == ST_SHIFT  ? (last ? (PAR_EN ? ST_PARITY : tail) : ST_SHIFT) :
           state == ST_PARITY ? tail :
                                (gap_cnt == GAP_LAST ? ST_IDLE : ST_GAP);
  end
  // state, shift register and terminal-compare counters; live masks ready until reset is released
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      live    <= 1'b0;
    end else begin
      live    <= 1'b1;
      state   <= nxt;
      sr      <= accept ? data_in :
                 state == ST_SHIFT ? (MSB_FIRST != 0 ? sr << 1 : sr >> 1) : sr;
      bit_cnt <= (state == ST_SHIFT && !last) ? bit_cnt + 1'b1 : '0;
      gap_cnt <= state == ST_GAP ? gap_cnt + 1'b1 : '0;
    end
  // outputs decode only registered state, so the first bit lands the cycle after accept
  always_comb begin
    ser_valid  = (state == ST_SHIFT) | (state == ST_PARITY);
    ser_out    = state == ST_SHIFT  ? (MSB_FIRST != 0 ? sr[WIDTH-1] : sr[0]) :
                 state == ST_PARITY ? par_bit : IDLE_LEVEL;
    busy       = state != ST_IDLE;
    frame_done = ((state == ST_SHIFT) & last & !PAR_EN) | (state == ST_PARITY);
  end
endmodule
